// File: rtl/lane_trajectory_executor.sv
// Purpose : rate-limited lateral/velocity trajectory executor feeding car position back to the planner.
// Latency : a command is accepted in one cycle; motion advances one step per motion tick (TICK_DIV clocks).
// Backpressure: o_cmd_ready low while a manoeuvre runs; an offered command is held off, never dropped.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_cmd_valid  target command valid
//   o_cmd_ready  executor can accept a command (combinational from state)
//   i_target_x   requested lateral position
//   i_target_v   requested velocity
//   o_pos_x      current lateral position
//   o_pos_y      accumulated longitudinal distance, mod 256
//   o_vel        current velocity
//   o_lane       00 left (x 1-4), 01 middle (5-8), 10 right (9-12), otherwise 00
//   o_busy       manoeuvre in progress
//   o_done       one-cycle pulse when both targets are reached
//
// Build option
//   CMD_PREEMPT_EN : when defined, commands are also accepted while moving and
//                    replace the current targets immediately.

module lane_trajectory_executor #(
   parameter int TICK_DIV = 4,
   parameter int X_STEP   = 1,
   parameter int V_STEP   = 5,
   parameter int X_MIN    = 1,
   parameter int X_MAX    = 12,
   parameter int V_MAX    = 120,
   parameter int X_RESET  = 6,
   parameter int V_RESET  = 50
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic [7:0] i_target_x,
   input  logic [7:0] i_target_v,
   output logic [7:0] o_pos_x,
   output logic [7:0] o_pos_y,
   output logic [7:0] o_vel,
   output logic [1:0] o_lane,
   output logic       o_busy,
   output logic       o_done
);

   localparam int         CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [7:0] LP_X_MIN  = 8'(X_MIN);
   localparam logic [7:0] LP_X_MAX  = 8'(X_MAX);
   localparam logic [7:0] LP_V_MAX  = 8'(V_MAX);
   localparam logic [7:0] LP_X_STEP = 8'(X_STEP);
   localparam logic [7:0] LP_V_STEP = 8'(V_STEP);
   localparam logic [7:0] LP_X_RST  = 8'(X_RESET);
   localparam logic [7:0] LP_V_RST  = 8'(V_RESET);
   localparam logic [CW-1:0] LP_TICK_LAST = CW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------

   // Move cur toward tgt by at most step; never overshoots, never wraps.
   function automatic logic [7:0] f_step(input logic [7:0] cur,
                                         input logic [7:0] tgt,
                                         input logic [7:0] step);
      logic [7:0] d;
      logic [7:0] res;
      if (tgt >= cur) begin
         d   = tgt - cur;
         res = (d > step) ? (cur + step) : tgt;
      end else begin
         d   = cur - tgt;
         res = (d > step) ? (cur - step) : tgt;
      end
      return res;
   endfunction

   function automatic logic [1:0] f_lane(input logic [7:0] x);
      logic [1:0] l;
      if (x >= 8'd1 && x <= 8'd4)
         l = 2'b00;
      else if (x >= 8'd5 && x <= 8'd8)
         l = 2'b01;
      else if (x >= 8'd9 && x <= 8'd12)
         l = 2'b10;
      else
         l = 2'b00;
      return l;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t        r_state;
   logic [CW-1:0] r_tick_cnt;
   logic [7:0]    r_pos_x;
   logic [7:0]    r_pos_y;
   logic [7:0]    r_vel;
   logic [1:0]    r_lane;
   logic          r_busy;
   logic          r_done;
   logic [7:0]    r_tgt_x;
   logic [7:0]    r_tgt_v;

   logic          w_tick;
   logic          w_accept;
   logic [7:0]    w_cmd_x;
   logic [7:0]    w_cmd_v;
   logic [7:0]    w_tgt_x;
   logic [7:0]    w_tgt_v;
   logic [7:0]    w_next_x;
   logic [7:0]    w_next_v;
   logic          w_arrive;

   assign w_tick = (r_tick_cnt == LP_TICK_LAST);

   // Incoming targets are clamped to the legal road and speed envelope.
   assign w_cmd_x = (i_target_x < LP_X_MIN) ? LP_X_MIN :
                    (i_target_x > LP_X_MAX) ? LP_X_MAX : i_target_x;
   assign w_cmd_v = (i_target_v > LP_V_MAX) ? LP_V_MAX : i_target_v;

`ifdef CMD_PREEMPT_EN
   assign o_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_MOVE);
   // A command landing on a tick steers that very tick toward the new target.
   assign w_tgt_x     = w_accept ? w_cmd_x : r_tgt_x;
   assign w_tgt_v     = w_accept ? w_cmd_v : r_tgt_v;
`else
   assign o_cmd_ready = (r_state == ST_IDLE);
   // Stepping only happens in MOVE, where no accept can occur.
   assign w_tgt_x     = r_tgt_x;
   assign w_tgt_v     = r_tgt_v;
`endif

   assign w_accept = i_cmd_valid && o_cmd_ready;

   assign w_next_x = f_step(r_pos_x, w_tgt_x, LP_X_STEP);
   assign w_next_v = f_step(r_vel,   w_tgt_v, LP_V_STEP);
   assign w_arrive = (w_next_x == w_tgt_x) && (w_next_v == w_tgt_v);

   // ------------------------------------------------------------------
   // Sequential logic: tick counter, odometer, FSM and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_tick_cnt <= '0;
         r_pos_x    <= LP_X_RST;
         r_pos_y    <= 8'd0;
         r_vel      <= LP_V_RST;
         r_lane     <= 2'b01;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_tgt_x    <= LP_X_RST;
         r_tgt_v    <= LP_V_RST;
      end else begin
         // Free-running; commands never realign the motion grid.
         if (w_tick)
            r_tick_cnt <= '0;
         else
            r_tick_cnt <= r_tick_cnt + 1'b1;

         // Odometer advances with the pre-step velocity, coarse units, wraps freely.
         if (w_tick)
            r_pos_y <= r_pos_y + {3'b000, r_vel[7:3]};

         if (w_accept) begin
            r_tgt_x <= w_cmd_x;
            r_tgt_v <= w_cmd_v;
         end

         r_done <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_busy <= 1'b0;
               if (w_accept) begin
                  r_state <= ST_MOVE;
                  r_busy  <= 1'b1;
               end
            end

            ST_MOVE: begin
               if (w_tick) begin
                  r_pos_x <= w_next_x;
                  r_vel   <= w_next_v;
                  r_lane  <= f_lane(w_next_x);
                  if (w_arrive) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_pos_x = r_pos_x;
   assign o_pos_y = r_pos_y;
   assign o_vel   = r_vel;
   assign o_lane  = r_lane;
   assign o_busy  = r_busy;
   assign o_done  = r_done;

endmodule
